// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic { INIT, RUN } state_e;

    typedef enum logic [1:0] { G_NONE, G_PIPE, G_MDU } grant_e;

    // One pending register write: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // A write is real unless it targets r0 while r0 is hard-wired to zero.
    function automatic logic wr_allowed(input logic [ADDR_W-1:0] rd, input bit zero_r0);
        return (rd != '0) || !zero_r0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback sources, MDU handshake and regfile write-port signals.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              pipe_stall;
    logic              init_busy;
    logic              err_proto;
    logic              RegWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;

    // Driver side: pipeline WB stage, MDU and an observer of the regfile port.
    modport master (
        output pipe_we, pipe_reg, pipe_data, mdu_valid, mdu_reg, mdu_data,
        input  mdu_ready, pipe_stall, init_busy, err_proto,
               RegWrite, writeReg, writeData
    );

    // Arbiter side.
    modport slave (
        input  pipe_we, pipe_reg, pipe_data, mdu_valid, mdu_reg, mdu_data,
        output mdu_ready, pipe_stall, init_busy, err_proto,
               RegWrite, writeReg, writeData
    );

endinterface

// File: rtl/regfile_wr_skid.sv
// One-entry buffer for MDU results, with an age counter that raises
// pipe_stall when a buffered result has been passed over too long.
module regfile_wr_skid
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    run,
    input  logic    mdu_valid,
    input  wr_req_t mdu_req,
    output logic    mdu_ready,
    input  logic    drain,
    output logic    buf_valid,
    output wr_req_t buf_req,
    output logic    pipe_stall
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              load;

    // Only accept while running and empty, so accept and drain never coincide.
    assign mdu_ready = run & ~buf_valid;
    // Results aimed at r0 are handshaken but never stored.
    assign load = mdu_valid & mdu_ready & wr_allowed(mdu_req.rd, ZERO_R0);

    // Buffer fill/drain and aging; the counter parks at its last value while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid  <= 1'b0;
            buf_req    <= '0;
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else if (drain) begin
            buf_valid  <= 1'b0;
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_req   <= mdu_req;
            wait_cnt  <= '0;
        end else if (buf_valid) begin
            if (wait_cnt == WAIT_LAST) pipe_stall <= 1'b1;
            else                       wait_cnt   <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the regfile write port: clears all registers after reset, then
// merges WB-stage writes (priority) with buffered MDU results.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);

    state_e            state;
    logic [ADDR_W-1:0] cnt;
    grant_e            grant;
    wr_req_t           mdu_req;
    wr_req_t           buf_req;
    logic              buf_valid;
    logic              drain;
    logic              run;

    assign run     = (state == RUN);
    assign mdu_req = '{rd: bus.mdu_reg, data: bus.mdu_data};
    assign drain   = (grant == G_MDU);

    regfile_wr_skid #(
        .MAX_WAIT (MAX_WAIT),
        .ZERO_R0  (ZERO_R0)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mdu_valid  (bus.mdu_valid),
        .mdu_req    (mdu_req),
        .mdu_ready  (bus.mdu_ready),
        .drain      (drain),
        .buf_valid  (buf_valid),
        .buf_req    (buf_req),
        .pipe_stall (bus.pipe_stall)
    );

    // Pipe beats the buffer; a pipe write to r0 is not a grant and lets the buffer drain.
    always_comb begin
        grant = G_NONE;
        if (run) begin
            if (bus.pipe_we && wr_allowed(bus.pipe_reg, ZERO_R0)) grant = G_PIPE;
            else if (buf_valid)                                   grant = G_MDU;
        end
    end

    // INIT sweep, RUN output mux and sticky protocol error, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            cnt           <= '0;
            bus.init_busy <= 1'b1;
            bus.err_proto <= 1'b0;
            bus.RegWrite  <= 1'b0;
            bus.writeReg  <= '0;
            bus.writeData <= '0;
        end else begin
            if (bus.pipe_we && (bus.pipe_stall || bus.init_busy))
                bus.err_proto <= 1'b1;
            case (state)
                INIT: begin
                    bus.RegWrite  <= 1'b1;
                    bus.writeReg  <= cnt;
                    bus.writeData <= '0;
                    cnt           <= cnt + 1'b1;
                    if (cnt == ADDR_W'(NREGS - 1)) begin
                        state         <= RUN;
                        bus.init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    case (grant)
                        G_PIPE: begin
                            bus.RegWrite  <= 1'b1;
                            bus.writeReg  <= bus.pipe_reg;
                            bus.writeData <= bus.pipe_data;
                        end
                        G_MDU: begin
                            bus.RegWrite  <= 1'b1;
                            bus.writeReg  <= buf_req.rd;
                            bus.writeData <= buf_req.data;
                        end
                        default: bus.RegWrite <= 1'b0;
                    endcase
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic against a transaction-level model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .ZERO_R0  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: progress through INIT, a queue of pending MDU results
    // and the edge number each one arrived on.
    bit          m_run;
    int          m_idx;
    wr_req_t     m_q[$];
    int          m_load_edge;
    int          edge_n;
    bit          m_stall, m_err, m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    typedef struct {
        logic        pwe;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_rdy;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                          input logic mv, input logic [4:0] mreg, input logic [31:0] mdata);
        bus.pipe_we   = pwe;
        bus.pipe_reg  = preg;
        bus.pipe_data = pdata;
        bus.mdu_valid = mv;
        bus.mdu_reg   = mreg;
        bus.mdu_data  = mdata;
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_idx  = 0;
        m_q.delete();
        m_stall = 1'b0;
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        edge_n  = 0;
        m_load_edge = 0;
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic model_step();
        bit      rdy;
        wr_req_t e;
        edge_n++;
        if (!m_run) begin
            if (bus.pipe_we) m_err = 1'b1;
            m_we   = 1'b1;
            m_reg  = 5'(m_idx);
            m_data = '0;
            m_idx++;
            if (m_idx == NREGS) m_run = 1'b1;
        end else begin
            rdy = (m_q.size() == 0);
            if (bus.pipe_we && m_stall) m_err = 1'b1;
            if (bus.pipe_we && bus.pipe_reg != 5'd0) begin
                m_we = 1'b1; m_reg = bus.pipe_reg; m_data = bus.pipe_data;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_we = 1'b1; m_reg = e.rd; m_data = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (rdy && bus.mdu_valid && bus.mdu_reg != 5'd0) begin
                e.rd = bus.mdu_reg;
                e.data = bus.mdu_data;
                m_q.push_back(e);
                m_load_edge = edge_n;
            end
            m_stall = (m_q.size() > 0) && (edge_n - m_load_edge >= MAX_WAIT);
        end
    endtask

    task automatic compare_all();
        check("RegWrite",   32'(bus.RegWrite),   32'(m_we));
        check("writeReg",   32'(bus.writeReg),   32'(m_reg));
        check("writeData",  bus.writeData,       m_data);
        check("init_busy",  32'(bus.init_busy),  32'(!m_run));
        check("mdu_ready",  32'(bus.mdu_ready),  32'(m_run && m_q.size() == 0));
        check("pipe_stall", 32'(bus.pipe_stall), 32'(m_stall));
        check("err_proto",  32'(bus.err_proto),  32'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Hold reset across an edge, check the reset state, release away from the edge.
    task automatic reset_and_release();
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic run_init();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            tick();
            check("init_writeReg", 32'(bus.writeReg), 32'(i));
        end
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            set_in($urandom_range(0, 99) < 70,
                   ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom,
                   $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            tick();
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
        vt[1] = '{1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
        vt[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
        vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 1'b1};
        vt[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h12345678, 1'b1};
        vt[5] = '{1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd4, 32'hBBBB0004, 1'b1, 5'd3, 32'hAAAA0003, 1'b0};
        vt[6] = '{1'b1, 5'd0, 32'hCCCC0000, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'hBBBB0004, 1'b1};
        vt[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hDDDD0000, 1'b0, 5'd4, 32'hBBBB0004, 1'b1};
        vt[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 32'hBBBB0004, 1'b1};

        // Reset state, then INIT sweep of r0..r31.
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("rst_init_busy", 32'(bus.init_busy), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            tick();
            check("init_writeReg", 32'(bus.writeReg), 32'(i));
            check("init_RegWrite", 32'(bus.RegWrite), 32'd1);
            check("init_busy_seq", 32'(bus.init_busy), 32'(i < NREGS - 1));
            check("init_mdu_ready", 32'(bus.mdu_ready), 32'(i == NREGS - 1));
        end

        // Directed pipe / MDU / r0 vectors.
        for (int i = 0; i < 9; i++) begin
            set_in(vt[i].pwe, vt[i].preg, vt[i].pdata, vt[i].mv, vt[i].mreg, vt[i].mdata);
            tick();
            check("vec_RegWrite",  32'(bus.RegWrite),  32'(vt[i].e_we));
            check("vec_writeReg",  32'(bus.writeReg),  32'(vt[i].e_reg));
            check("vec_writeData", bus.writeData,      vt[i].e_data);
            check("vec_mdu_ready", 32'(bus.mdu_ready), 32'(vt[i].e_rdy));
        end

        // Starved MDU result forces a stall after MAX_WAIT edges of waiting.
        set_in(1'b1, 5'd1, 32'h00000001, 1'b1, 5'd9, 32'hC0FFEE09);
        tick();
        check("stall_buffered", 32'(bus.mdu_ready), 32'd0);
        for (int k = 1; k <= MAX_WAIT; k++) begin
            set_in(1'b1, 5'(k + 1), 32'(k + 1), 1'b0, 5'd0, 32'd0);
            tick();
            check("stall_timing", 32'(bus.pipe_stall), 32'(k == MAX_WAIT));
        end
        // Pipe writes through a stall: still wins, flags a protocol error.
        set_in(1'b1, 5'd20, 32'h20202020, 1'b0, 5'd0, 32'd0);
        tick();
        check("stall_pipe_wins", 32'(bus.writeReg), 32'd20);
        check("stall_err", 32'(bus.err_proto), 32'd1);
        check("stall_held", 32'(bus.pipe_stall), 32'd1);
        // Pipe backs off: buffered r9 drains and the stall clears on that edge.
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("drain_reg", 32'(bus.writeReg), 32'd9);
        check("drain_data", bus.writeData, 32'hC0FFEE09);
        check("drain_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        check("err_sticky", 32'(bus.err_proto), 32'd1);

        // Randomized traffic in two chunks so err_proto starts clean in each.
        for (int r = 0; r < 2; r++) begin
            reset_and_release();
            run_init();
            random_run(250);
        end

        // Reset pulse mid-INIT after a protocol error; INIT must restart at r0.
        reset_and_release();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.pipe_we = (i == 5);
            tick();
        end
        check("mid_init_err", 32'(bus.err_proto), 32'd1);
        bus.pipe_we = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("async_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("async_writeReg", 32'(bus.writeReg), 32'd0);
        check("async_err", 32'(bus.err_proto), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_init();
        tick();
        check("post_init_idle", 32'(bus.RegWrite), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
